sap1_controller_sequencer: RTL and testbench

SAP-1 controller-sequencer: a 6-state one-hot ring counter (T1–T6) built on the same falling-edge discipline as the team's JK flip-flop building block, plus microinstruction decode that drives the 12-bit control word to the PC, MAR, RAM, IR, accumulator, adder/subtracter, B and output registers. It sits between the instruction register opcode nibble and every control input of the datapath. It also owns the halt condition.

---
 rtl/sap1_controller_sequencer_if.sv | 22 ++
 rtl/sap1_controller_sequencer.sv | 143 ++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sap1_controller_sequencer_if.sv
// Control bundle between the SAP-1 controller-sequencer and the datapath it steers.
// The master side decodes the opcode into the control word and ring state.
interface sap1_controller_sequencer_if;
    logic [3:0]  i;
    logic [11:0] con;
    logic [5:0]  t;
    logic        hlt;

    modport master (
        input  i,
        output con,
        output t,
        output hlt
    );

    modport slave (
        output i,
        input  con,
        input  t,
        input  hlt
    );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: a falling-edge one-hot T1..T6 ring, a sticky halt flag,
// and the combinational microinstruction decode that forms the 12-bit control word.
module sap1_controller_sequencer (
    input  logic                         clk,
    input  logic                         rst,
    sap1_controller_sequencer_if.master  bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_state_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // Field order matches the control word bit order, MSB first.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = 12'h3E3;

    logic [5:0] t_q;
    logic [5:0] t_d;
    logic       hlt_q;
    logic       hlt_d;
    logic       ring_legal;
    ctrl_t      ctrl;

    assign ring_legal = $onehot(t_q);

    // The halt decision is taken on the edge that leaves T3, so the ring parks in T4.
    always_comb begin
        t_d   = T1;
        hlt_d = hlt_q;
        if (!ring_legal) begin
            t_d = T1;
        end else if (hlt_q) begin
            t_d = t_q;
        end else begin
            t_d = {t_q[4:0], t_q[5]};
            if ((t_q == T3) && (bus.i == OP_HLT)) begin
                hlt_d = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            t_q   <= T1;
            hlt_q <= 1'b0;
        end else begin
            t_q   <= t_d;
            hlt_q <= hlt_d;
        end
    end

    always_comb begin
        ctrl = CTRL_NOP;
        if (!hlt_q) begin
            case (t_q)
                T1: begin
                    ctrl.ep   = 1'b1;
                    ctrl.lm_n = 1'b0;
                end
                T2: begin
                    ctrl.cp = 1'b1;
                end
                T3: begin
                    ctrl.ce_n = 1'b0;
                    ctrl.li_n = 1'b0;
                end
                T4: begin
                    case (bus.i)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.lm_n = 1'b0;
                            ctrl.ei_n = 1'b0;
                        end
                        OP_OUT: begin
                            ctrl.ea   = 1'b1;
                            ctrl.lo_n = 1'b0;
                        end
                        default: ctrl = CTRL_NOP;
                    endcase
                end
                T5: begin
                    case (bus.i)
                        OP_LDA: begin
                            ctrl.ce_n = 1'b0;
                            ctrl.la_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ce_n = 1'b0;
                            ctrl.lb_n = 1'b0;
                        end
                        default: ctrl = CTRL_NOP;
                    endcase
                end
                T6: begin
                    case (bus.i)
                        OP_ADD: begin
                            ctrl.la_n = 1'b0;
                            ctrl.eu   = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl.la_n = 1'b0;
                            ctrl.su   = 1'b1;
                            ctrl.eu   = 1'b1;
                        end
                        default: ctrl = CTRL_NOP;
                    endcase
                end
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

    assign bus.con = ctrl;
    assign bus.t   = t_q;
    assign bus.hlt = hlt_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench for the SAP-1 controller-sequencer: expected ring state, control
// word and halt flag are queued as stimulus is driven and compared once the DUT settles.
module tb_sap1_controller_sequencer;

    typedef struct {
        string       name;
        logic [5:0]  t;
        logic [11:0] con;
        logic        hlt;
    } expect_t;

    typedef struct {
        logic [3:0]  opcode;
        logic [11:0] con_t4;
        logic [11:0] con_t5;
        logic [11:0] con_t6;
    } vec_t;

    logic clk;
    logic rst;
    int   check_count;
    int   fail_count;
    expect_t scoreboard[$];
    vec_t    vectors[6];

    sap1_controller_sequencer_if bus();

    sap1_controller_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pushExpect(input string name, input logic [5:0] t,
                              input logic [11:0] con, input logic hlt);
        expect_t e;
        e.name = name;
        e.t    = t;
        e.con  = con;
        e.hlt  = hlt;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        check_count++;
        if (scoreboard.size() == 0) begin
            fail_count++;
            $display("[TB] FAIL scoreboard_empty got=0 expected=1");
            return;
        end
        e = scoreboard.pop_front();
        if (bus.t !== e.t) begin
            fail_count++;
            $display("[TB] FAIL %s.t got=%b expected=%b", e.name, bus.t, e.t);
        end
        check_count++;
        if (bus.con !== e.con) begin
            fail_count++;
            $display("[TB] FAIL %s.con got=%h expected=%h", e.name, bus.con, e.con);
        end
        check_count++;
        if (bus.hlt !== e.hlt) begin
            fail_count++;
            $display("[TB] FAIL %s.hlt got=%b expected=%b", e.name, bus.hlt, e.hlt);
        end
    endtask

    // Drive the opcode ahead of the falling edge, then sample well after it.
    task automatic applyStimulus(input logic [3:0] opcode, input string name,
                                 input logic [5:0] t, input logic [11:0] con,
                                 input logic hlt);
        bus.i = opcode;
        pushExpect(name, t, con, hlt);
        @(negedge clk);
        #2;
        checkOutput();
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        vectors[0] = '{4'b0001, 12'h1A3, 12'h2E1, 12'h3C7};
        vectors[1] = '{4'b0010, 12'h1A3, 12'h2E1, 12'h3CF};
        vectors[2] = '{4'b0111, 12'h3E3, 12'h3E3, 12'h3E3};
        vectors[3] = '{4'b1001, 12'h3E3, 12'h3E3, 12'h3E3};
        vectors[4] = '{4'b0000, 12'h1A3, 12'h2C3, 12'h3E3};
        vectors[5] = '{4'b1110, 12'h3F2, 12'h3E3, 12'h3E3};

        rst   = 1'b1;
        bus.i = 4'b0000;
        #3;
        pushExpect("reset", 6'h01, 12'h5E3, 1'b0);
        checkOutput();
        @(posedge clk);
        rst = 1'b0;

        applyStimulus(4'h0, "lda_t2", 6'h02, 12'hBE3, 1'b0);
        applyStimulus(4'h0, "lda_t3", 6'h04, 12'h263, 1'b0);
        applyStimulus(4'h0, "lda_t4", 6'h08, 12'h1A3, 1'b0);
        applyStimulus(4'h0, "lda_t5", 6'h10, 12'h2C3, 1'b0);
        applyStimulus(4'h0, "lda_t6", 6'h20, 12'h3E3, 1'b0);
        applyStimulus(4'h0, "lda_wrap", 6'h01, 12'h5E3, 1'b0);

        // Random opcodes during fetch must not disturb the fetch words.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(4'($urandom_range(0, 15)), "vec_t2", 6'h02, 12'hBE3, 1'b0);
            applyStimulus(4'($urandom_range(0, 15)), "vec_t3", 6'h04, 12'h263, 1'b0);
            applyStimulus(vectors[v].opcode, "vec_t4", 6'h08, vectors[v].con_t4, 1'b0);
            applyStimulus(vectors[v].opcode, "vec_t5", 6'h10, vectors[v].con_t5, 1'b0);
            applyStimulus(vectors[v].opcode, "vec_t6", 6'h20, vectors[v].con_t6, 1'b0);
            applyStimulus(vectors[v].opcode, "vec_wrap", 6'h01, 12'h5E3, 1'b0);
        end

        applyStimulus(4'h3, "hlt_t2", 6'h02, 12'hBE3, 1'b0);
        applyStimulus(4'h5, "hlt_t3", 6'h04, 12'h263, 1'b0);
        applyStimulus(4'hF, "hlt_enter", 6'h08, 12'h3E3, 1'b1);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), "hlt_hold", 6'h08, 12'h3E3, 1'b1);
        end
        rst = 1'b1;
        #1;
        pushExpect("hlt_clear", 6'h01, 12'h5E3, 1'b0);
        checkOutput();
        @(posedge clk);
        rst = 1'b0;

        applyStimulus(4'h1, "mid_t2", 6'h02, 12'hBE3, 1'b0);
        applyStimulus(4'h1, "mid_t3", 6'h04, 12'h263, 1'b0);
        applyStimulus(4'h1, "mid_t4", 6'h08, 12'h1A3, 1'b0);
        applyStimulus(4'h1, "mid_t5", 6'h10, 12'h2E1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        pushExpect("mid_reset", 6'h01, 12'h5E3, 1'b0);
        checkOutput();
        @(posedge clk);
        rst = 1'b0;
        applyStimulus(4'h1, "refetch_t2", 6'h02, 12'hBE3, 1'b0);
        applyStimulus(4'h1, "refetch_t3", 6'h04, 12'h263, 1'b0);

        force dut.t_q = 6'b000000;
        #1;
        release dut.t_q;
        applyStimulus(4'h0, "illegal_zero", 6'h01, 12'h5E3, 1'b0);
        force dut.t_q = 6'b010100;
        #1;
        release dut.t_q;
        applyStimulus(4'h0, "illegal_multi", 6'h01, 12'h5E3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
